ysyx_22040931_wb_arbiter: RTL and testbench
===========================================

# ysyx_22040931_wb_arbiter

Writeback arbiter sitting directly upstream of the register file's single write port. It merges in-order results from the MEM stage with out-of-order results from the long-latency unit (mul/div), buffered in a small FIFO. Load data is aligned and extended here, and one registered write per cycle is driven to the register file (`w_ena`/`w_addr`/`w_data`).

## Interface
- `XLEN`, 64, datapath width
- `LU_DEPTH`, 2, long-latency result FIFO depth (power of two, ≥2)

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `mem_valid`  in  1  MEM-stage result valid
- `mem_ready`  out  1  arbiter accepts MEM result this cycle
- `mem_wen`  in  1  instruction writes rd
- `mem_rd`  in  5  destination register
- `mem_is_load`  in  1  `mem_result` is a raw 64-bit memory word
- `mem_ld_size`  in  2  00 byte, 01 half, 10 word, 11 double
- `mem_ld_unsigned`  in  1  zero-extend (else sign-extend)
- `mem_addr_lo`  in  3  load address bits [2:0]
- `mem_result`  in  XLEN  ALU result or raw load word
- `lu_valid`  in  1  long-latency result valid
- `lu_ready`  out  1  FIFO not full
- `lu_rd`  in  5  destination register
- `lu_data`  in  XLEN  result
- `w_ena`  out  1  register-file write enable (registered)
- `w_addr`  out  5  register-file write address (registered)
- `w_data`  out  XLEN  register-file write data (registered)
- `wb_retire`  out  1  one-cycle pulse per granted transaction (registered)
- `wb_misalign`  out  1  one-cycle pulse: granted load was misaligned (registered)

## Operation
- LU handshake: push when `lu_valid && lu_ready`; `lu_ready = !fifo_full`, independent of `lu_valid`. No bypass: a pushed entry is eligible the next cycle.
- Arbitration uses the state bit `last_grant` (MEM/LU):
  - `lu_pri = fifo_nonempty && (fifo_full || last_grant==MEM)`.
  - `mem_ready = !lu_pri`.
  - `grant_mem = mem_valid && mem_ready`.
  - `grant_lu = fifo_nonempty && !grant_mem`.
- `last_grant` updates only on a grant. Alternation under contention means neither source starves; a full FIFO always wins.
- FIFO: circular buffer with read/write pointers that wrap mod `LU_DEPTH`, plus a count. Simultaneous push and pop leaves the count unchanged. Push while full cannot occur.
- Load extraction when `mem_is_load`:
  - Shift `mem_result` right by `mem_addr_lo*8`.
  - Take the low 8/16/32/64 bits per `mem_ld_size`, then sign- or zero-extend to XLEN. `ld_unsigned` with double is a plain copy.
  - Misaligned cases: half at odd offset, word with `addr_lo[1:0]!=0`, double with `addr_lo!=0`. These produce `w_data=0`, `w_ena=0`, `wb_misalign=1`, `wb_retire=1`.
- Write qualification:
  - MEM: `w_ena` = `mem_wen && mem_rd!=0 && !misaligned`.
  - LU: `w_ena` = `lu_rd!=0`.
  - x0 writes still retire. `w_addr`/`w_data` update only on a grant with `w_ena=1`, otherwise they hold their value.
- No grant in a cycle: next cycle `w_ena=0`, `wb_retire=0`, `wb_misalign=0`.

## Timing
- MEM accepted at edge T → `w_*`/`wb_retire` valid in cycle T+1. The register file forwards the value to same-cycle readers.
- LU accepted at edge T → earliest grant T+1 → `w_*` valid T+2.
- Throughput is one writeback per cycle.
- Reset (asynchronous, any time, including mid-transfer):
  - All outputs go to 0, except `mem_ready=1` and `lu_ready=1` from the emptied FIFO.
  - FIFO count and pointers go to 0; `last_grant`=LU.
  - In-flight FIFO entries are discarded.
- After reset deasserts, the first cycle may grant.

## Structure
- Shared package (defines file) holds:
  - `XLEN`.
  - Load size codes `LD_B/LD_H/LD_W/LD_D`.
  - `GRANT_MEM/GRANT_LU` encodings.
  - A zero constant for 64-bit values.
- Sub-module `ysyx_22040931_wb_fifo` is a generic parameterised sync FIFO (width, depth) with asynchronous active-high reset. It provides `push/pop/full/empty` and a head-data output, and holds 5+XLEN per entry.
- The arbiter contains the grant logic, load extractor (combinational function) and output registers.

## Test plan
- MEM only, back-to-back ALU writes rd=5 `0x1234`, then rd=0 `0xFFFF`: cycle 1 `w_ena=1 w_addr=5 w_data=0x1234`; cycle 2 `w_ena=0`, `wb_retire=1`.
- Loads with `mem_result=0x8877_6655_4433_2211`:
  - lb at `addr_lo=7` → `0xFFFF_FFFF_FFFF_FF88`.
  - lhu at 2 → `0x4433`.
  - lw at 4 → `0xFFFF_FFFF_8877_6655`.
  - lh at 3 → `wb_misalign=1`, `w_ena=0`.
- Contention: MEM held valid; LU pushes 3 results. `lu_ready` drops after 2 pending. Grants alternate MEM/LU, with LU forced while full. All 3 LU writes appear in push order.
- FIFO wrap: 10 LU results, one per cycle, with MEM idle → 10 consecutive writes, 2-cycle latency each, with no loss across pointer wrap.
- Asynchronous reset asserted mid-cycle with FIFO full and `w_ena=1`: outputs zero immediately, with no clock edge. After release, the stale entries never write, and `lu_ready=mem_ready=1`.

Source files
------------

// File: rtl/ysyx_22040931_wb_arbiter_pkg.sv
// Shared definitions for the writeback arbiter: datapath width, load size codes
// and grant-source encodings.
package ysyx_22040931_wb_arbiter_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    LD_B = 2'b00,
    LD_H = 2'b01,
    LD_W = 2'b10,
    LD_D = 2'b11
  } ld_size_e;

  typedef enum logic {
    GRANT_MEM = 1'b0,
    GRANT_LU  = 1'b1
  } grant_e;

  localparam logic [63:0] ZERO64 = 64'h0;

endpackage

// File: rtl/ysyx_22040931_wb_fifo.sv
// Generic synchronous FIFO: circular buffer with wrapping read/write pointers and
// an occupancy count. The head entry is presented combinationally on rdata.
module ysyx_22040931_wb_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // NOTE: storage carries no reset; an entry is only ever read after the count
  // says it was written, so clearing the array would buy nothing.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22040931_wb_arbiter.sv
// Writeback arbiter: merges in-order MEM results with buffered long-latency results
// into one registered register-file write per cycle, aligning/extending load data.
module ysyx_22040931_wb_arbiter #(
  parameter int XLEN     = 64,
  parameter int LU_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_wen,
  input  logic [4:0]      mem_rd,
  input  logic            mem_is_load,
  input  logic [1:0]      mem_ld_size,
  input  logic            mem_ld_unsigned,
  input  logic [2:0]      mem_addr_lo,
  input  logic [XLEN-1:0] mem_result,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            w_ena,
  output logic [4:0]      w_addr,
  output logic [XLEN-1:0] w_data,
  output logic            wb_retire,
  output logic            wb_misalign
);

  import ysyx_22040931_wb_arbiter_pkg::*;

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [1:0]      size,
                                                   input logic            uns,
                                                   input logic [2:0]      lo);
    logic [XLEN-1:0] s;
    s = word >> {lo, 3'b000};
    case (size)
      LD_B:    return uns ? {{(XLEN-8){1'b0}}, s[7:0]}   : {{(XLEN-8){s[7]}}, s[7:0]};
      LD_H:    return uns ? {{(XLEN-16){1'b0}}, s[15:0]} : {{(XLEN-16){s[15]}}, s[15:0]};
      LD_W:    return uns ? {{(XLEN-32){1'b0}}, s[31:0]} : {{(XLEN-32){s[31]}}, s[31:0]};
      default: return s;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo);
    case (size)
      LD_H:    return lo[0];
      LD_W:    return lo[1:0] != 2'b00;
      LD_D:    return lo != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  grant_e          last_grant;
  logic            fifo_full;
  logic            fifo_empty;
  logic            lu_push;
  logic [4+XLEN:0] fifo_head;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_data;
  logic            lu_pri;
  logic            grant_mem;
  logic            grant_lu;

  logic            mem_mis;
  logic [XLEN-1:0] mem_wdata;
  logic            nxt_ena;
  logic [4:0]      nxt_addr;
  logic [XLEN-1:0] nxt_data;

  assign lu_ready = !fifo_full;
  assign lu_push  = lu_valid && lu_ready;

  ysyx_22040931_wb_fifo #(
    .WIDTH (5 + XLEN),
    .DEPTH (LU_DEPTH)
  ) u_lu_fifo (
    .clock (clock),
    .reset (reset),
    .push  (lu_push),
    .pop   (grant_lu),
    .wdata ({lu_rd, lu_data}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_rd, head_data} = fifo_head;

  // Alternate under contention; a full FIFO always takes the port.
  assign lu_pri    = !fifo_empty && (fifo_full || last_grant == GRANT_MEM);
  assign mem_ready = !lu_pri;
  assign grant_mem = mem_valid && mem_ready;
  assign grant_lu  = !fifo_empty && !grant_mem;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    mem_mis   = mem_is_load && is_misaligned(mem_ld_size, mem_addr_lo);
    mem_wdata = mem_result;
    if (mem_is_load)
      mem_wdata = mem_mis ? XLEN'(ZERO64)
                          : load_extract(mem_result, mem_ld_size, mem_ld_unsigned, mem_addr_lo);

    nxt_ena  = 1'b0;
    nxt_addr = w_addr;
    nxt_data = w_data;
    if (grant_mem) begin
      nxt_ena  = mem_wen && (mem_rd != 5'd0) && !mem_mis;
      nxt_addr = mem_rd;
      nxt_data = mem_wdata;
    end else if (grant_lu) begin
      nxt_ena  = (head_rd != 5'd0);
      nxt_addr = head_rd;
      nxt_data = head_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant  <= GRANT_LU;
      w_ena       <= 1'b0;
      w_addr      <= '0;
      w_data      <= '0;
      wb_retire   <= 1'b0;
      wb_misalign <= 1'b0;
    end else begin
      w_ena       <= nxt_ena;
      wb_retire   <= grant_mem || grant_lu;
      wb_misalign <= grant_mem && mem_mis;
      // Address/data hold unless a real write is issued.
      if (nxt_ena) begin
        w_addr <= nxt_addr;
        w_data <= nxt_data;
      end
      if (grant_mem)     last_grant <= GRANT_MEM;
      else if (grant_lu) last_grant <= GRANT_LU;
    end
  end

endmodule

// File: tb/tb_ysyx_22040931_wb_arbiter.sv
// Directed self-checking bench for the writeback arbiter: ALU/load writes,
// MEM/LU contention, FIFO pointer wrap and asynchronous reset mid-transfer.
module tb_ysyx_22040931_wb_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid, mem_ready, mem_wen, mem_is_load, mem_ld_unsigned;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_ld_size;
  logic [2:0]  mem_addr_lo;
  logic [63:0] mem_result;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_rd;
  logic [63:0] lu_data;
  logic        w_ena, wb_retire, wb_misalign;
  logic [4:0]  w_addr;
  logic [63:0] w_data;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [63:0] LD_WORD = 64'h8877_6655_4433_2211;

  always #5 clock = ~clock;

  ysyx_22040931_wb_arbiter #(.XLEN(64), .LU_DEPTH(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_wen         (mem_wen),
    .mem_rd          (mem_rd),
    .mem_is_load     (mem_is_load),
    .mem_ld_size     (mem_ld_size),
    .mem_ld_unsigned (mem_ld_unsigned),
    .mem_addr_lo     (mem_addr_lo),
    .mem_result      (mem_result),
    .lu_valid        (lu_valid),
    .lu_ready        (lu_ready),
    .lu_rd           (lu_rd),
    .lu_data         (lu_data),
    .w_ena           (w_ena),
    .w_addr          (w_addr),
    .w_data          (w_data),
    .wb_retire       (wb_retire),
    .wb_misalign     (wb_misalign)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_mem(input logic v, input logic wen, input logic [4:0] rd, input logic [63:0] res);
    mem_valid   = v;
    mem_wen     = wen;
    mem_rd      = rd;
    mem_result  = res;
    mem_is_load = 1'b0;
  endtask

  task automatic set_load(input logic [1:0] size, input logic uns, input logic [2:0] lo);
    mem_valid       = 1'b1;
    mem_wen         = 1'b1;
    mem_rd          = 5'd7;
    mem_result      = LD_WORD;
    mem_is_load     = 1'b1;
    mem_ld_size     = size;
    mem_ld_unsigned = uns;
    mem_addr_lo     = lo;
  endtask

  initial begin
    reset = 1'b1;
    set_mem(1'b0, 1'b0, 5'd0, 64'h0);
    mem_ld_size = 2'b00; mem_ld_unsigned = 1'b0; mem_addr_lo = 3'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 64'h0;

    // Reset state
    #3;
    check("rst_w_ena", w_ena, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_w_data", w_data, 0);
    check("rst_retire", wb_retire, 0);
    check("rst_misalign", wb_misalign, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_lu_ready", lu_ready, 1);
    tick();
    reset = 1'b0;

    // Back-to-back ALU writes: rd=5 then x0
    set_mem(1'b1, 1'b1, 5'd5, 64'h1234);
    tick();
    check("alu1_ena", w_ena, 1);
    check("alu1_addr", w_addr, 5);
    check("alu1_data", w_data, 64'h1234);
    check("alu1_retire", wb_retire, 1);
    set_mem(1'b1, 1'b1, 5'd0, 64'hFFFF);
    tick();
    check("alu_x0_ena", w_ena, 0);
    check("alu_x0_retire", wb_retire, 1);
    check("alu_x0_hold_addr", w_addr, 5);
    check("alu_x0_hold_data", w_data, 64'h1234);
    set_mem(1'b0, 1'b0, 5'd0, 64'h0);
    tick();
    check("idle_retire", wb_retire, 0);
    check("idle_ena", w_ena, 0);

    // Loads
    set_load(2'b00, 1'b0, 3'd7); tick();
    check("lb7_ena", w_ena, 1);
    check("lb7_data", w_data, 64'hFFFF_FFFF_FFFF_FF88);
    set_load(2'b01, 1'b1, 3'd2); tick();
    check("lhu2_data", w_data, 64'h4433);
    set_load(2'b10, 1'b0, 3'd4); tick();
    check("lw4_data", w_data, 64'hFFFF_FFFF_8877_6655);
    set_load(2'b00, 1'b1, 3'd1); tick();
    check("lbu1_data", w_data, 64'h22);
    set_load(2'b11, 1'b0, 3'd0); tick();
    check("ld0_data", w_data, 64'h8877_6655_4433_2211);
    check("ld0_misalign", wb_misalign, 0);
    set_load(2'b01, 1'b0, 3'd3); tick();
    check("lh3_misalign", wb_misalign, 1);
    check("lh3_ena", w_ena, 0);
    check("lh3_retire", wb_retire, 1);
    set_load(2'b10, 1'b0, 3'd2); tick();
    check("lw2_misalign", wb_misalign, 1);
    check("lw2_ena", w_ena, 0);
    set_mem(1'b0, 1'b0, 5'd0, 64'h0);
    tick();
    check("mis_clear", wb_misalign, 0);

    // Contention: MEM held valid, LU pushes three results
    set_mem(1'b1, 1'b1, 5'd10, 64'hAAAA);
    lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 64'h100;
    #1;
    check("ct0_mem_ready", mem_ready, 1);
    tick();
    check("ct1_addr", w_addr, 10);
    check("ct1_data", w_data, 64'hAAAA);
    mem_result = 64'hBBBB;
    lu_rd = 5'd21; lu_data = 64'h101;
    #1;
    check("ct1_mem_stalled", mem_ready, 0);
    tick();
    check("ct2_addr", w_addr, 20);
    check("ct2_data", w_data, 64'h100);
    lu_rd = 5'd22; lu_data = 64'h102;
    #1;
    check("ct2_mem_ready", mem_ready, 1);
    tick();
    check("ct3_data", w_data, 64'hBBBB);
    mem_result = 64'hCCCC;
    lu_valid = 1'b0;
    #1;
    check("ct3_lu_full", lu_ready, 0);
    check("ct3_mem_stalled", mem_ready, 0);
    tick();
    check("ct4_addr", w_addr, 21);
    check("ct4_data", w_data, 64'h101);
    check("ct4_lu_ready", lu_ready, 1);
    tick();
    check("ct5_data", w_data, 64'hCCCC);
    set_mem(1'b0, 1'b0, 5'd0, 64'h0);
    tick();
    check("ct6_addr", w_addr, 22);
    check("ct6_data", w_data, 64'h102);
    tick();
    check("ct7_retire", wb_retire, 0);

    // FIFO wrap: ten LU results, one per cycle, MEM idle
    for (int i = 0; i <= 10; i++) begin
      lu_valid = (i < 10);
      lu_rd    = 5'(i + 1);
      lu_data  = 64'h1000 + 64'(i);
      tick();
      if (i == 0) begin
        check("wrap_first_latency", wb_retire, 0);
      end else begin
        check("wrap_ena", w_ena, 1);
        check("wrap_addr", w_addr, 64'(i));
        check("wrap_data", w_data, 64'h1000 + 64'(i - 1));
      end
    end
    lu_valid = 1'b0;
    tick();
    check("wrap_drained", wb_retire, 0);

    // LU write to x0 retires without writing
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 64'hDEAD;
    tick();
    lu_valid = 1'b0;
    tick();
    check("lu_x0_retire", wb_retire, 1);
    check("lu_x0_ena", w_ena, 0);
    check("lu_x0_hold_addr", w_addr, 10);

    // Fill the FIFO under contention, then reset asynchronously mid-cycle
    set_mem(1'b1, 1'b1, 5'd3, 64'h33);
    lu_valid = 1'b1; lu_rd = 5'd4; lu_data = 64'h44;
    tick();
    lu_rd = 5'd5; lu_data = 64'h55;
    tick();
    lu_rd = 5'd6; lu_data = 64'h66;
    tick();
    check("pre_rst_ena", w_ena, 1);
    check("pre_rst_addr", w_addr, 3);
    check("pre_rst_full", lu_ready, 0);
    set_mem(1'b0, 1'b0, 5'd0, 64'h0);
    lu_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_ena", w_ena, 0);
    check("arst_addr", w_addr, 0);
    check("arst_data", w_data, 0);
    check("arst_retire", wb_retire, 0);
    check("arst_lu_ready", lu_ready, 1);
    check("arst_mem_ready", mem_ready, 1);
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_retire", wb_retire, 0);
      check("post_rst_ena", w_ena, 0);
      check("post_rst_lu_ready", lu_ready, 1);
      check("post_rst_mem_ready", mem_ready, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
